// File: rtl/uart_tx_gen2.sv
// uart_tx_gen2: FIFO-buffered UART transmitter with programmable frame format,
// break generation, FIFO level, sticky overflow and a frame-done strobe.
module uart_tx_gen2 #(
  parameter int UART_DATA_WIDTH        = 8,
  parameter int UART_TX_FIFO_DEPTH     = 8,
  parameter int UART_TX_FIFO_PTR_WIDTH = 4
) (
  input  logic                              PCLK,
  input  logic                              PRESET,
  input  logic                              tx_baud_pulse,
  input  logic                              tx_data_wr,
  input  logic [UART_DATA_WIDTH-1:0]        tx_data,
  input  logic [1:0]                        data_len,
  input  logic [1:0]                        parity_mode,
  input  logic                              stop2,
  input  logic                              break_en,
  input  logic                              overflow_clr,
  output logic                              UART_TX,
  output logic                              tx_ready,
  output logic [UART_TX_FIFO_PTR_WIDTH-1:0] tx_fifo_level,
  output logic                              tx_busy,
  output logic                              tx_done,
  output logic                              tx_overflow
);

  localparam int PW = UART_TX_FIFO_PTR_WIDTH;
  localparam int AW = UART_TX_FIFO_PTR_WIDTH - 1;
  localparam logic [PW-1:0] DEPTH_L = PW'(UART_TX_FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK
  } state_t;

  // FIFO storage; pointers carry one extra wrap bit so full/empty are distinct
  logic [UART_DATA_WIDTH-1:0] mem [UART_TX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, level;
  logic          full, empty, pop, push_ok, ovf_set, ovf_q;
  logic [UART_DATA_WIDTH-1:0] head;

  state_t state_q, state_d;
  logic [UART_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d, last_bit;
  logic [1:0] len_q, len_d, par_q, par_d;
  logic       stop2_q, stop2_d, par_bit_q, par_bit_d, brk_q, brk_d;
  logic       line_q, line_d, done_q, done_d;
  logic [UART_DATA_WIDTH-1:0] mask;
  logic       head_xor, par_calc;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr[AW-1:0]];
  // a pop in the same cycle frees an entry, so a push into a full FIFO is kept
  assign push_ok = tx_data_wr && (!full || pop);
  assign ovf_set = tx_data_wr && full && !pop;

  // parity of the head byte restricted to the configured data length
  assign mask     = 8'hFF >> (2'd3 - data_len);
  assign head_xor = ^(head & mask);
  always_comb begin
    par_calc = 1'b0;
    case (parity_mode)
      2'b01:   par_calc = ~head_xor;
      2'b10:   par_calc = head_xor;
      2'b11:   par_calc = 1'b1;
      default: par_calc = 1'b0;
    endcase
  end

  assign last_bit = {1'b0, len_q} + 3'd4;

  // FIFO storage write (contents are discarded on reset via the pointers)
  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  // FIFO pointers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // sticky overflow; a new overflow beats a simultaneous clear
  always_ff @(posedge PCLK) begin
    if (PRESET)            ovf_q <= 1'b0;
    else if (ovf_set)      ovf_q <= 1'b1;
    else if (overflow_clr) ovf_q <= 1'b0;
  end

  // FSM state and frame datapath registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      par_q     <= '0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      brk_q     <= 1'b0;
      line_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      par_bit_q <= par_bit_d;
      brk_q     <= brk_d;
      line_q    <= line_d;
      done_q    <= done_d;
    end
  end

  // next state, next line level and pop decision; moves only on baud pulses
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    par_bit_d = par_bit_q;
    brk_d     = brk_q;
    line_d    = line_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    if (tx_baud_pulse) begin
      case (state_q)
        S_IDLE: begin
          line_d = 1'b1;
          if (break_en) begin
            state_d = S_BREAK;
            line_d  = 1'b0;
          end else if (!empty) begin
            pop       = 1'b1;
            state_d   = S_START;
            line_d    = 1'b0;
            shift_d   = head;
            len_d     = data_len;
            par_d     = parity_mode;
            stop2_d   = stop2;
            par_bit_d = par_calc;
            brk_d     = 1'b0;
          end
        end
        S_START: begin
          state_d = S_DATA;
          line_d  = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
        S_DATA: begin
          if (cnt_q == last_bit) begin
            if (par_q != 2'b00) begin
              state_d = S_PARITY;
              line_d  = par_bit_q;
            end else begin
              state_d = S_STOP1;
              line_d  = 1'b1;
            end
          end else begin
            line_d  = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 3'd1;
          end
        end
        S_PARITY: begin
          state_d = S_STOP1;
          line_d  = 1'b1;
        end
        S_STOP1: begin
          line_d = 1'b1;
          if (stop2_q) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_IDLE;
            done_d  = !brk_q;
          end
        end
        S_STOP2: begin
          state_d = S_IDLE;
          line_d  = 1'b1;
          done_d  = 1'b1;
        end
        S_BREAK: begin
          if (!break_en) begin
            // single stop bit after a break, and no done strobe for it
            state_d = S_STOP1;
            line_d  = 1'b1;
            stop2_d = 1'b0;
            brk_d   = 1'b1;
          end else begin
            line_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          line_d  = 1'b1;
        end
      endcase
    end
  end

  assign UART_TX       = line_q;
  assign tx_ready      = !full;
  assign tx_fifo_level = level;
  assign tx_busy       = (state_q != S_IDLE);
  assign tx_done       = done_q;
  assign tx_overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Directed bench for uart_tx_gen2: frame shapes, parity, FIFO, break, reset.
module tb_uart_tx_gen2;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       tx_baud_pulse;
  logic       tx_data_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] data_len = 2'b11;
  logic [1:0] parity_mode = 2'b00;
  logic       stop2 = 1'b0;
  logic       break_en = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       UART_TX, tx_ready, tx_busy, tx_done, tx_overflow;
  logic [3:0] tx_fifo_level;

  logic       baud_on = 1'b0;
  logic       pulse_force = 1'b0;
  logic [3:0] div_cnt = 4'd0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  uart_tx_gen2 dut (
    .PCLK(PCLK), .PRESET(PRESET), .tx_baud_pulse(tx_baud_pulse),
    .tx_data_wr(tx_data_wr), .tx_data(tx_data), .data_len(data_len),
    .parity_mode(parity_mode), .stop2(stop2), .break_en(break_en),
    .overflow_clr(overflow_clr), .UART_TX(UART_TX), .tx_ready(tx_ready),
    .tx_fifo_level(tx_fifo_level), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_overflow(tx_overflow)
  );

  always #5 PCLK = ~PCLK;

  // divide-by-16 baud strobe, plus a manual override for forced pulses
  assign tx_baud_pulse = pulse_force | (baud_on && div_cnt == 4'd15);
  always @(posedge PCLK) begin
    div_cnt <= baud_on ? div_cnt + 4'd1 : 4'd0;
    cyc     <= cyc + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  task automatic push(input logic [7:0] b);
    tx_data    = b;
    tx_data_wr = 1'b1;
    @(negedge PCLK);
    tx_data_wr = 1'b0;
  endtask

  // waits for a start bit, samples each bit centre, then checks done and busy
  task automatic check_frame(input string name, input int nbits, input logic [15:0] exp,
                             input int period, output int t_start);
    logic [15:0] vec;
    int w, d0;
    vec = '0;
    w = 0;
    t_start = 0;
    d0 = done_cnt;
    while (UART_TX !== 1'b0 && w < 3000) begin
      @(negedge PCLK);
      w++;
    end
    checks++;
    if (w >= 3000) begin
      errors++;
      $display("FAIL %s start: no start bit seen, line=%b expected 0", name, UART_TX);
      return;
    end
    t_start = cyc;
    repeat (period / 2) @(negedge PCLK);
    for (int i = 0; i < nbits; i++) begin
      vec[i] = UART_TX;
      if (i < nbits - 1) repeat (period) @(negedge PCLK);
    end
    repeat (period / 2 + 2) @(negedge PCLK);
    checks++;
    if (vec !== exp) begin
      errors++;
      $display("FAIL %s bits: got %b expected %b", name, vec, exp);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL %s done: got %0d pulses expected 1", name, done_cnt - d0);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: got %b expected 0", name, tx_busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({UART_TX, tx_ready, tx_fifo_level, tx_busy, tx_done, tx_overflow} !== {1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got tx=%b rdy=%b lvl=%0d busy=%b done=%b ovf=%b expected 1 1 0 0 0 0",
               UART_TX, tx_ready, tx_fifo_level, tx_busy, tx_done, tx_overflow);
    end
  endtask

  task automatic test_8n1();
    int t;
    data_len = 2'b11; parity_mode = 2'b00; stop2 = 1'b0;
    baud_on = 1'b1;
    push(8'hA5);
    check_frame("8n1_a5", 10, {6'b0, 1'b1, 8'hA5, 1'b0}, 16, t);
  endtask

  task automatic test_parity();
    int t;
    data_len = 2'b10; parity_mode = 2'b10; stop2 = 1'b1;
    push(8'h53);
    check_frame("7e2_53", 11, {5'b0, 1'b1, 1'b1, 1'b0, 7'h53, 1'b0}, 16, t);
    data_len = 2'b00; parity_mode = 2'b01; stop2 = 1'b0;
    push(8'hFF);
    check_frame("5o1_ff", 8, {8'b0, 1'b1, 1'b0, 5'h1F, 1'b0}, 16, t);
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    logic [7:0] b [3];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
    data_len = 2'b11; parity_mode = 2'b00; stop2 = 1'b0;
    baud_on = 1'b0;
    for (int i = 0; i < 3; i++) push(b[i]);
    checks++;
    if (tx_fifo_level !== 4'd3) begin
      errors++;
      $display("FAIL b2b level0: got %0d expected 3", tx_fifo_level);
    end
    baud_on = 1'b1;
    check_frame("b2b_0", 10, {6'b0, 1'b1, b[0], 1'b0}, 16, t0);
    checks++;
    if (tx_fifo_level !== 4'd2) begin
      errors++;
      $display("FAIL b2b level1: got %0d expected 2", tx_fifo_level);
    end
    check_frame("b2b_1", 10, {6'b0, 1'b1, b[1], 1'b0}, 16, t1);
    checks++;
    if (tx_fifo_level !== 4'd1) begin
      errors++;
      $display("FAIL b2b level2: got %0d expected 1", tx_fifo_level);
    end
    check_frame("b2b_2", 10, {6'b0, 1'b1, b[2], 1'b0}, 16, t2);
    checks++;
    if (tx_fifo_level !== 4'd0) begin
      errors++;
      $display("FAIL b2b level3: got %0d expected 0", tx_fifo_level);
    end
    checks++;
    if (t1 - t0 !== 176 || t2 - t1 !== 176) begin
      errors++;
      $display("FAIL b2b gap: got %0d,%0d cycles expected 176,176", t1 - t0, t2 - t1);
    end
  endtask

  task automatic test_break();
    int t, t_rise, w, d0;
    data_len = 2'b11; parity_mode = 2'b00; stop2 = 1'b0;
    baud_on = 1'b0;
    push(8'h5A);
    push(8'h3C);
    baud_on = 1'b1;
    fork
      check_frame("brk_f1", 10, {6'b0, 1'b1, 8'h5A, 1'b0}, 16, t);
      begin
        repeat (40) @(negedge PCLK);
        break_en = 1'b1;
      end
    join
    repeat (48) @(negedge PCLK);
    d0 = done_cnt;
    checks++;
    if ({UART_TX, tx_busy, tx_fifo_level} !== {1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL brk_hold: got tx=%b busy=%b lvl=%0d expected 0 1 1", UART_TX, tx_busy, tx_fifo_level);
    end
    repeat (40) @(negedge PCLK);
    checks++;
    if (UART_TX !== 1'b0) begin
      errors++;
      $display("FAIL brk_hold2: got tx=%b expected 0", UART_TX);
    end
    break_en = 1'b0;
    w = 0;
    while (UART_TX !== 1'b1 && w < 100) begin
      @(negedge PCLK);
      w++;
    end
    t_rise = cyc;
    checks++;
    if (w >= 100) begin
      errors++;
      $display("FAIL brk_release: line stayed %b expected 1", UART_TX);
    end
    check_frame("brk_f2", 10, {6'b0, 1'b1, 8'h3C, 1'b0}, 16, t);
    checks++;
    if (t - t_rise !== 32) begin
      errors++;
      $display("FAIL brk_gap: got %0d cycles expected 32", t - t_rise);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL brk_nodone: got %0d pulses expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_continuous_pulse();
    int t;
    baud_on = 1'b0;
    pulse_force = 1'b1;
    push(8'h96);
    check_frame("cont_96", 10, {6'b0, 1'b1, 8'h96, 1'b0}, 1, t);
    pulse_force = 1'b0;
  endtask

  task automatic test_overflow();
    baud_on = 1'b0;
    pulse_force = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i + 1));
    checks++;
    if ({tx_fifo_level, tx_ready, tx_overflow} !== {4'd8, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ovf_full: got lvl=%0d rdy=%b ovf=%b expected 8 0 0", tx_fifo_level, tx_ready, tx_overflow);
    end
    push(8'h99);
    checks++;
    if ({tx_fifo_level, tx_overflow} !== {4'd8, 1'b1}) begin
      errors++;
      $display("FAIL ovf_set: got lvl=%0d ovf=%b expected 8 1", tx_fifo_level, tx_overflow);
    end
    overflow_clr = 1'b1;
    @(negedge PCLK);
    overflow_clr = 1'b0;
    checks++;
    if (tx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b expected 0", tx_overflow);
    end
    overflow_clr = 1'b1;
    push(8'h98);
    overflow_clr = 1'b0;
    checks++;
    if (tx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_setwins: got %b expected 1", tx_overflow);
    end
    overflow_clr = 1'b1;
    @(negedge PCLK);
    overflow_clr = 1'b0;
    // push and pop on the same edge while full: accepted, level unchanged
    pulse_force = 1'b1;
    push(8'hEE);
    pulse_force = 1'b0;
    checks++;
    if ({tx_fifo_level, tx_overflow, tx_busy} !== {4'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_pushpop: got lvl=%0d ovf=%b busy=%b expected 8 0 1", tx_fifo_level, tx_overflow, tx_busy);
    end
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    checks++;
    if ({tx_fifo_level, tx_busy, UART_TX} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_reset: got lvl=%0d busy=%b tx=%b expected 0 0 1", tx_fifo_level, tx_busy, UART_TX);
    end
  endtask

  task automatic test_reset_mid_frame();
    int w;
    data_len = 2'b11; parity_mode = 2'b00; stop2 = 1'b0;
    baud_on = 1'b0;
    for (int i = 0; i < 3; i++) push(8'h00);
    baud_on = 1'b1;
    w = 0;
    while (UART_TX !== 1'b0 && w < 100) begin
      @(negedge PCLK);
      w++;
    end
    repeat (40) @(negedge PCLK);
    checks++;
    if ({UART_TX, tx_busy, tx_fifo_level} !== {1'b0, 1'b1, 4'd2}) begin
      errors++;
      $display("FAIL rst_mid_pre: got tx=%b busy=%b lvl=%0d expected 0 1 2", UART_TX, tx_busy, tx_fifo_level);
    end
    PRESET = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({UART_TX, tx_busy, tx_fifo_level, tx_ready} !== {1'b1, 1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid: got tx=%b busy=%b lvl=%0d rdy=%b expected 1 0 0 1",
               UART_TX, tx_busy, tx_fifo_level, tx_ready);
    end
    PRESET = 1'b0;
    baud_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_break();
    test_continuous_pulse();
    test_overflow();
    test_reset_mid_frame();
    repeat (4) @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_gen2.md
Name: uart_tx_gen2

Overview:
Parametrised second-generation UART transmitter for the APB UART peripheral. It buffers bytes in an internal FIFO and serialises them on UART_TX, one bit per tx_baud_pulse period. Data length (5-8 bits), parity mode (none/odd/even/mark) and stop-bit count (1/2) are programmable, and it adds break generation, FIFO level reporting, a sticky overflow flag and a frame-done strobe. It sits between the UART register block (write side) and the baud generator (tx_baud_pulse).

Parameters:
UART_DATA_WIDTH, 8, FIFO entry width; must be 8.
UART_TX_FIFO_DEPTH, 8, number of FIFO entries; power of two, 2 to 256.
UART_TX_FIFO_PTR_WIDTH, 4, must equal log2(UART_TX_FIFO_DEPTH)+1; it is also the width of tx_fifo_level.

Ports:
PCLK  input  1  clock; all logic on rising edge.
PRESET  input  1  synchronous, active-high reset.
tx_baud_pulse  input  1  one-PCLK strobe; one bit time = interval between strobes.
tx_data_wr  input  1  push tx_data into FIFO this cycle.
tx_data  input  8  byte to transmit; LSB is sent first.
data_len  input  2  00=5, 01=6, 10=7, 11=8 data bits.
parity_mode  input  2  00=none, 01=odd, 10=even, 11=mark (constant 1).
stop2  input  1  0=one stop bit, 1=two stop bits.
break_en  input  1  level request to hold the line low.
overflow_clr  input  1  clears tx_overflow.
UART_TX  output  1  serial line, registered.
tx_ready  output  1  FIFO not full.
tx_fifo_level  output  UART_TX_FIFO_PTR_WIDTH  current number of FIFO entries.
tx_busy  output  1  state is not IDLE.
tx_done  output  1  one-cycle pulse when a frame's last stop bit ends.
tx_overflow  output  1  sticky: a write was attempted while the FIFO was full.

Behaviour:
- Reset values: UART_TX=1, state=IDLE, FIFO empty, tx_fifo_level=0, tx_ready=1, tx_busy=0, tx_done=0, tx_overflow=0. Reset mid-frame aborts the frame, returns UART_TX to 1 on the next edge and discards all FIFO contents.
- FIFO write: a write with the FIFO not full stores the byte and raises the level on the next edge. A write while full drops the byte and sets tx_overflow. If overflow_clr and a new overflow occur in the same cycle, the set wins.
- FIFO pop: in IDLE, on a tx_baud_pulse with the FIFO not empty and break_en=0, the head byte is loaded into the shift register and popped. The same edge latches data_len/parity_mode/stop2 for this frame; later config changes only affect later frames.
- Push and pop in the same cycle: level unchanged; push is accepted even when full, because the pop frees an entry.
- States advance only on edges where tx_baud_pulse=1. UART_TX is updated on the same edge as the state, so each bit lasts exactly one baud period:
  - IDLE (line 1)
  - START (line 0)
  - DATA (line = shift[0], shift right; bit counter 0..N-1)
  - PARITY (line = XNOR of active bits for odd, XOR for even, 1 for mark; bits above N are excluded)
  - STOP1 (line 1)
  - STOP2 (line 1)
  - BREAK (line 0)
- Transitions, each on a baud pulse:
  - IDLE→START when the pop condition holds.
  - IDLE→BREAK when break_en=1; break has priority over FIFO data.
  - START→DATA.
  - DATA→PARITY/STOP1 after bit N-1, depending on parity_mode.
  - PARITY→STOP1.
  - STOP1→STOP2 if stop2 latched, else →IDLE.
  - STOP2→IDLE.
  - BREAK stays while break_en=1; on the first pulse with break_en=0 → STOP1 with one stop bit, then IDLE, with no tx_done.
- tx_done pulses for one PCLK on the edge leaving the final stop state of a data frame.
- Back-to-back frames: on the pulse that ends the final stop bit, the FSM enters IDLE with the line at 1. The next frame's START begins on the following pulse, giving at least one idle bit.
- break_en asserted mid-frame has no effect until the frame completes.
- tx_baud_pulse held high continuously is legal: the FSM advances one state per PCLK.

Test Plan:
- 8N1, write 0xA5, pulse every 16 clocks → line 1,0, then 1,0,1,0,0,1,0,1, then 1, each bit 16 clocks; tx_done pulses once; tx_busy=0 afterwards.
- 7E2, write 0x53 → data bits 1,1,0,0,1,0,1; parity=0 (four ones); two stop bits of 1. 5O1, write 0xFF → data 1,1,1,1,1; parity=0.
- Write 9 bytes back-to-back with DEPTH=8 and no baud pulses → level=8, tx_ready=0 after the 8th write; 9th dropped and tx_overflow=1; overflow_clr → tx_overflow=0.
- Write 3 bytes, 8N1 → three frames in order, each separated by one idle bit; level decrements at each pop; three tx_done pulses.
- break_en=1 during an 8N1 frame → frame completes, then line 0 for as long as break_en is held; release → one stop bit of 1, IDLE, queued data resumes, no tx_done for the break.
- Assert PRESET mid-DATA with 2 entries queued → next edge gives UART_TX=1, level=0, tx_busy=0.
